// File: rtl/post_pixel_pack_pkg.sv
// Shared types and constants for the write-back pixel packer.
package pixel_pkg;

  typedef logic [23:0] rgb_pixel_t;

  localparam int unsigned PIXELS_PER_GROUP = 4;
  localparam int unsigned WORDS_PER_GROUP  = 3;
  localparam int unsigned WORD_BYTES       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WORD1,
    ST_WORD2,
    ST_WORD3,
    ST_DONE
  } pack_state_t;

  typedef logic [1:0] word_idx_t;

  // Word slot within the current group; only meaningful in the WORDn states.
  function automatic word_idx_t word_index(input pack_state_t s);
    case (s)
      ST_WORD2: return 2'd1;
      ST_WORD3: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/post_pixel_pack_word_mux.sv
// Forms one 32-bit output word from a held 4-pixel group and a word index.
// Build option: PACK_BYTE_SWAP_EN byte-reverses the word for little-endian memory.
module pack_word_mux
  import pixel_pkg::*;
(
  input  rgb_pixel_t [PIXELS_PER_GROUP-1:0] i_pixels,
  input  word_idx_t                         i_word_idx,
  output logic       [31:0]                 o_word
);

  logic [31:0] w_word_be;

  always_comb begin
    w_word_be = '0;
    case (i_word_idx)
      2'd0:    w_word_be = {i_pixels[3], i_pixels[2][23:16]};
      2'd1:    w_word_be = {i_pixels[2][15:0], i_pixels[1][23:8]};
      2'd2:    w_word_be = {i_pixels[1][7:0], i_pixels[0]};
      default: w_word_be = '0;
    endcase
  end

`ifdef PACK_BYTE_SWAP_EN
  assign o_word = {w_word_be[7:0], w_word_be[15:8], w_word_be[23:16], w_word_be[31:24]};
`else
  assign o_word = w_word_be;
`endif

endmodule

// File: rtl/post_pixel_pack.sv
// Packs 4-pixel RGB groups into three big-endian 32-bit words and writes them over req/ack.
// Build option: PACK_BYTE_SWAP_EN (little-endian word byte order, see pack_word_mux).
module post_pixel_pack
  import pixel_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned GROUP_W = 16
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                start_en,
  input  logic       [ADDR_W-1:0]             base_addr,
  input  logic       [GROUP_W-1:0]            num_groups,
  input  rgb_pixel_t [PIXELS_PER_GROUP-1:0]   pixels_in,
  input  logic                                pixels_valid,
  output logic                                pixels_ready,
  output logic       [31:0]                   write_word,
  output logic       [ADDR_W-1:0]             write_addr,
  output logic                                write_req,
  input  logic                                write_ack,
  output logic                                busy,
  output logic                                done
);

  pack_state_t                        r_state;
  pack_state_t                        w_next;
  logic       [ADDR_W-1:0]            r_addr;
  logic       [GROUP_W-1:0]           r_num;
  logic       [GROUP_W-1:0]           r_count;
  logic       [GROUP_W-1:0]           w_count_inc;
  rgb_pixel_t [PIXELS_PER_GROUP-1:0]  r_pix;
  logic       [31:0]                  w_mux_word;
  logic                               w_in_word;

  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_num   <= '0;
      r_count <= '0;
      r_pix   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start_en) begin
            r_addr  <= base_addr;
            r_num   <= num_groups;
            r_count <= '0;
          end
        end
        ST_LOAD: begin
          if (pixels_valid) r_pix <= pixels_in;
        end
        ST_WORD1, ST_WORD2: begin
          if (write_ack) r_addr <= r_addr + ADDR_W'(WORD_BYTES);
        end
        ST_WORD3: begin
          if (write_ack) begin
            r_addr  <= r_addr + ADDR_W'(WORD_BYTES);
            r_count <= w_count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // Decided from the live num_groups: it is latched on this same edge.
        if (start_en) w_next = (num_groups == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD:  if (pixels_valid) w_next = ST_WORD1;
      ST_WORD1: if (write_ack) w_next = ST_WORD2;
      ST_WORD2: if (write_ack) w_next = ST_WORD3;
      ST_WORD3: if (write_ack) w_next = (w_count_inc == r_num) ? ST_DONE : ST_LOAD;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  pack_word_mux u_word_mux (
    .i_pixels   (r_pix),
    .i_word_idx (word_index(r_state)),
    .o_word     (w_mux_word)
  );

  always_comb begin
    w_in_word    = (r_state == ST_WORD1) || (r_state == ST_WORD2) || (r_state == ST_WORD3);
    pixels_ready = (r_state == ST_LOAD);
    write_req    = w_in_word;
    write_word   = w_in_word ? w_mux_word : '0;
    write_addr   = r_addr;
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
  end

endmodule

// File: tb/tb_post_pixel_pack.sv
// Randomized self-checking bench for post_pixel_pack against a byte-stream reference model.
module tb_post_pixel_pack;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start_en;
  logic [31:0]      base_addr;
  logic [15:0]      num_groups;
  logic [3:0][23:0] pixels_in;
  logic             pixels_valid;
  logic             pixels_ready;
  logic [31:0]      write_word;
  logic [31:0]      write_addr;
  logic             write_req;
  logic             write_ack;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  logic [31:0] seen_w[$];
  logic [31:0] seen_a[$];

  always #5 clk = ~clk;

  post_pixel_pack #(.ADDR_W(32), .GROUP_W(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start_en     (start_en),
    .base_addr    (base_addr),
    .num_groups   (num_groups),
    .pixels_in    (pixels_in),
    .pixels_valid (pixels_valid),
    .pixels_ready (pixels_ready),
    .write_word   (write_word),
    .write_addr   (write_addr),
    .write_req    (write_req),
    .write_ack    (write_ack),
    .busy         (busy),
    .done         (done)
  );

  // The group as a 12-byte stream in memory order, cut into 4-byte words.
  function automatic logic [31:0] model_word(input logic [3:0][23:0] g, input int k);
    logic [7:0]  s[12];
    logic [23:0] px;
    logic [31:0] w;
    for (int p = 0; p < 4; p++) begin
      px = g[3-p];
      s[3*p]   = px[23:16];
      s[3*p+1] = px[15:8];
      s[3*p+2] = px[7:0];
    end
    w = {s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]};
`ifdef PACK_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic run_job(input logic [31:0] base, input int n, input logic [3:0][23:0] first_grp,
                         input bit use_first, input int ack_max, input int stall_word,
                         input int vdelay, input int abort_word, input bit restart);
    logic [3:0][23:0] grps[$];
    logic [3:0][23:0] g;
    logic [31:0] exp_w[$];
    logic [31:0] exp_a[$];
    logic [31:0] prev_word, prev_addr;
    logic prev_req, prev_ack, prev_ready;
    int total, wi, gi, vcnt, ack_wait, cyc, done_cnt;
    bit finished, do_abort;
    for (int i = 0; i < n; i++) begin
      if (use_first && i == 0) g = first_grp;
      else for (int p = 0; p < 4; p++) g[p] = 24'($urandom);
      grps.push_back(g);
      for (int k = 0; k < 3; k++) begin
        exp_w.push_back(model_word(g, k));
        exp_a.push_back(base + 32'(4 * (3 * i + k)));
      end
    end
    total = 3 * n;
    wi = 0; gi = 0; vcnt = 0; ack_wait = 0; cyc = 0; done_cnt = 0;
    prev_req = 0; prev_ack = 0; prev_ready = 0; prev_word = '0; prev_addr = '0;
    finished = 0; do_abort = 0;
    seen_w.delete(); seen_a.delete();
    start_en = 1'b1; base_addr = base; num_groups = 16'(n);
    while (!finished) begin
      @(posedge clk); #1;
      start_en = 1'b0;
      if (pixels_valid && prev_ready) begin
        pixels_valid = 1'b0; gi++; vcnt = 0;
      end
      if (prev_req && prev_ack) wi++;
      write_ack = 1'b0;
      if (write_req) begin
        checks++;
        if (pixels_ready !== 1'b0) begin
          errors++; $display("FAIL ready_during_req: pixels_ready=%b required 0", pixels_ready);
        end
        if (!prev_req || prev_ack) begin
          seen_w.push_back(write_word); seen_a.push_back(write_addr);
          checks++;
          if (wi >= total) begin
            errors++; $display("FAIL extra_word: word %0d of %0d requested", wi, total);
          end else if (write_word !== exp_w[wi] || write_addr !== exp_a[wi]) begin
            errors++;
            $display("FAIL word%0d: got %h@%h required %h@%h", wi, write_word, write_addr, exp_w[wi], exp_a[wi]);
          end
          if (wi == abort_word) do_abort = 1;
          if (restart && wi == 2) begin
            start_en = 1'b1; base_addr = 32'h2000; num_groups = 16'd7;
          end
          ack_wait = ((wi % 3) == stall_word) ? 5 : $urandom_range(ack_max, 0);
        end else begin
          checks++;
          if (write_word !== prev_word || write_addr !== prev_addr) begin
            errors++;
            $display("FAIL stall_stable: got %h@%h required %h@%h", write_word, write_addr, prev_word, prev_addr);
          end
        end
        if (ack_wait == 0) write_ack = 1'b1;
        else ack_wait--;
      end else if ($urandom_range(3, 0) == 0) begin
        write_ack = 1'b1;
      end
      if (pixels_ready) begin
        checks++;
        if (gi >= n || done) begin
          errors++; $display("FAIL ready_unexpected: pixels_ready=1 after %0d of %0d groups", gi, n);
        end else if (vcnt >= vdelay) begin
          pixels_valid = 1'b1; pixels_in = grps[gi];
        end else vcnt++;
      end
      if (done) begin
        done_cnt++; checks++;
        if (wi != total || write_addr !== base + 32'(12 * n) || busy !== 1'b1) begin
          errors++;
          $display("FAIL done_state: words=%0d addr=%h busy=%b required words=%0d addr=%h busy=1",
                   wi, write_addr, busy, total, base + 32'(12 * n));
        end
        finished = 1;
      end
      prev_req = write_req; prev_ack = write_ack; prev_ready = pixels_ready;
      prev_word = write_word; prev_addr = write_addr;
      cyc++;
      if (cyc > 3000) begin
        errors++; checks++;
        $display("FAIL timeout: job base=%h n=%0d stuck at word %0d", base, n, wi);
        finished = 1;
      end
      if (do_abort) begin
        n_rst = 1'b0; write_ack = 1'b0; pixels_valid = 1'b0;
        #1;
        checks++;
        if (write_req !== 0 || pixels_ready !== 0 || busy !== 0 || done !== 0 ||
            write_word !== 0 || write_addr !== 0) begin
          errors++;
          $display("FAIL reset_async: req=%b rdy=%b busy=%b done=%b word=%h addr=%h required all 0",
                   write_req, pixels_ready, busy, done, write_word, write_addr);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        finished = 1;
      end
    end
    if (done_cnt == 1) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 0 || busy !== 0 || write_req !== 0 || write_addr !== base + 32'(12 * n)) begin
        errors++;
        $display("FAIL done_pulse: done=%b busy=%b req=%b addr=%h required 0 0 0 %h",
                 done, busy, write_req, write_addr, base + 32'(12 * n));
      end
    end
    pixels_valid = 1'b0; write_ack = 1'b0; start_en = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start_en = 0; base_addr = '0; num_groups = '0;
    pixels_in = '0; pixels_valid = 0; write_ack = 0;
    #3;
    checks++;
    if (write_req !== 0 || pixels_ready !== 0 || busy !== 0 || done !== 0 ||
        write_word !== 0 || write_addr !== 0) begin
      errors++;
      $display("FAIL reset_state: req=%b rdy=%b busy=%b done=%b word=%h addr=%h required all 0",
               write_req, pixels_ready, busy, done, write_word, write_addr);
    end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 0 || write_req !== 0 || pixels_ready !== 0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b req=%b rdy=%b required 0", busy, write_req, pixels_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0][23:0] g;
    logic [31:0] ew[3];
    g = {24'hAABBCC, 24'h112233, 24'h445566, 24'h778899};
`ifdef PACK_BYTE_SWAP_EN
    ew = '{32'h11CCBBAA, 32'h55443322, 32'h99887766};
`else
    ew = '{32'hAABBCC11, 32'h22334455, 32'h66778899};
`endif
    run_job(32'h1000, 1, g, 1, 0, -1, 0, -1, 0);
    checks++;
    if (seen_w.size() != 3) begin
      errors++; $display("FAIL single_count: %0d words required 3", seen_w.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen_w[i] !== ew[i] || seen_a[i] !== 32'h1000 + 32'(4 * i)) begin
          errors++;
          $display("FAIL single_word%0d: got %h@%h required %h@%h", i, seen_w[i], seen_a[i], ew[i], 32'h1000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_job(32'h1000, 2, '0, 0, 1, 1, 0, -1, 0);
  endtask

  task automatic test_multi();
    run_job(32'h1000, 3, '0, 0, 2, -1, 2, -1, 0);
    checks++;
    if (seen_a.size() != 9 || seen_a[8] !== 32'h1020) begin
      errors++; $display("FAIL multi_span: %0d words required 9 ending at 00001020", seen_a.size());
    end
  endtask

  task automatic test_zero_groups();
    start_en = 1'b1; base_addr = 32'h5000; num_groups = '0;
    @(posedge clk); #1;
    start_en = 1'b0;
    checks++;
    if (done !== 1 || busy !== 1 || write_req !== 0 || pixels_ready !== 0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b req=%b rdy=%b required 1 1 0 0", done, busy, write_req, pixels_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 0 || busy !== 0 || write_req !== 0 || pixels_ready !== 0) begin
        errors++;
        $display("FAIL zero_idle%0d: done=%b busy=%b req=%b rdy=%b required 0", i, done, busy, write_req, pixels_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_job(32'h3000, 2, '0, 0, 2, 1, 0, 1, 0);
    run_job(32'h4000, 1, '0, 0, 1, -1, 1, -1, 0);
  endtask

  task automatic test_start_ignored();
    run_job(32'h1000, 2, '0, 0, 1, -1, 0, -1, 1);
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int j = 0; j < 8; j++) begin
      b = (j == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      run_job(b, $urandom_range(4, 1), '0, 0, 3, -1, $urandom_range(3, 0), -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_multi();
    test_zero_groups();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/post_pixel_pack.md
Name: post_pixel_pack

Overview:
- Write-back packer for the edge-detection pipeline, sitting between the pixel-processing stages and the memory write master.
- Accepts groups of four 24-bit RGB pixels and packs each group into three consecutive 32-bit memory words, in big-endian pixel order.
- Issues each word with an incrementing byte address over a req/ack handshake.
- Counts groups and signals completion after a programmed number of groups.

Parameters:
ADDR_W, 32, width of base_addr and write_addr
GROUP_W, 16, width of num_groups and the internal group counter

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
start_en  in  1  one-cycle start pulse; ignored unless in IDLE
base_addr  in  ADDR_W  byte address of first output word, latched on start
num_groups  in  GROUP_W  number of 4-pixel groups to write, latched on start
pixels_in  in  [3:0][23:0]  pixel group; [3] is first in memory order
pixels_valid  in  1  pixels_in holds a valid group
pixels_ready  out  1  packer can accept a group this cycle
write_word  out  32  packed data word
write_addr  out  ADDR_W  byte address of write_word
write_req  out  1  word request; held until acked
write_ack  in  1  memory master accepted the current word
busy  out  1  not IDLE
done  out  1  one-cycle pulse after the last group is written

Behaviour:
- Reset: clk and n_rst are already decided — clk is the clock; n_rst is the reset, asynchronous, active-low. On reset the state is IDLE, and all outputs and registers clear to 0: pixels_ready=0, write_req=0, write_word=0, write_addr=0, busy=0, done=0, group count 0, pixel holding register 0. Reset mid-operation abandons the current group with no partial completion.
- States: IDLE, LOAD, WORD1, WORD2, WORD3, DONE. All outputs are registered or decoded from state only; there is no comb path from write_ack to write_req.
- IDLE: on start_en, latch base_addr and num_groups, and clear the group count.
  - If num_groups==0, go to DONE.
  - Otherwise go to LOAD.
- LOAD: pixels_ready=1. On pixels_valid, capture pixels_in into the holding register and go to WORD1. write_req rises the next cycle, so latency from accept to first req is 1 cycle.
- WORDn: write_req=1, and write_word/write_addr stay stable until write_ack. On ack, write_addr += 4 and the state advances.
  - WORD1 = {p3[23:0], p2[23:16]}
  - WORD2 = {p2[15:0], p1[23:8]}
  - WORD3 = {p1[7:0], p0[23:0]}
- A write_ack that arrives while write_req=0 is ignored.
- WORD3 ack: group count += 1.
  - If the new count == num_groups, go to DONE.
  - Otherwise go to LOAD. pixels_ready rises the cycle after the ack; there is no group overlap.
- DONE: done=1 for exactly one cycle, then IDLE. write_addr keeps its final value (base + 12*num_groups).
- busy=1 in every state except IDLE.
- start_en outside IDLE is ignored, with no relatch.
- pixels_valid outside LOAD is ignored. The source must hold the group until it sees pixels_ready.
- Address arithmetic wraps modulo 2^ADDR_W with no error.

Optional Feature:
PACK_BYTE_SWAP_EN
- Defined: write_word is byte-reversed ({b0,b1,b2,b3}) for little-endian memory. Addressing and handshake are unchanged.
- Undefined: write_word is as specified above.

Decomposition:
- Package pixel_pkg holds:
  - the typedef for rgb_pixel_t (24-bit)
  - the constants PIXELS_PER_GROUP=4, WORDS_PER_GROUP=3 and WORD_BYTES=4
  - the pack state enum
- One sub-module is natural: pack_word_mux, a combinational selector that forms a word from the holding register and the word index (with the byte swap applied under the macro).

Test Plan:
- Single group: base=0x1000, num_groups=1, pixels {0xAABBCC, 0x112233, 0x445566, 0x778899} with ack the cycle after each req -> writes 0xAABBCC11@0x1000, 0x22334455@0x1004, 0x66778899@0x1008; done pulses once; busy falls.
- Backpressure: hold write_ack low 5 cycles on WORD2 -> write_req, write_word and write_addr stay constant for all 5 cycles; no skipped or duplicated word.
- Multi-group: num_groups=3 with pixels_valid delayed 2 cycles per group -> 9 words at 0x1000..0x1020; pixels_ready high only in LOAD; done after the ninth ack.
- num_groups=0 -> no write_req; done pulses 1 cycle after start; pixels_ready never rises.
- Reset asserted mid-WORD2 -> all outputs 0 immediately; a new start after release begins at WORD1 of a fresh group.
- start_en pulsed during WORD3 with base=0x2000 -> ignored; addresses continue from the original base. PACK_BYTE_SWAP_EN build: first word of the single-group case = 0x11CCBBAA.
